gpio_irq: RTL and testbench

- Parametrised next-generation GPIO peripheral on the SoC slave bus. Pin count is configurable.
- Adds per-pin direction, atomic set/clear/toggle of outputs, and a configurable input synchronizer.
- Adds rising/falling edge detection with sticky write-1-to-clear status and a single registered interrupt line to the core.

---
 rtl/gpio_irq.sv | 118 +++++++++++
 tb/tb_gpio_irq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq.sv
// GPIO with per-pin direction, atomic set/clear/toggle, input synchronizer and edge interrupts.
// Reads are combinational; pad edge reaches irq after SYNC_STAGES+2 clk edges; no bus stalls.
module gpio_irq #(
   parameter int               WIDTH       = 16,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      bAddr,
   input  logic [31:0]      bWData,
   input  logic             bSel,
   input  logic             bWrite,
   input  logic [1:0]       mem_size,
   output logic [31:0]      bRData,
   input  logic [WIDTH-1:0] gpioInput,
   output logic [WIDTH-1:0] gpioOutput,
   output logic [WIDTH-1:0] gpioOutEn,
   output logic             irq
);

   localparam int            CW      = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0] ARM_MAX = CW'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_ff;
   logic [WIDTH-1:0] sync, prev, rise, fall, w1c_mask, wdata;
   logic [WIDTH-1:0] data_out, dir, irq_en, rise_en, fall_en, status;
   logic [CW-1:0]    arm_cnt;
   logic             armed, we;
   logic [5:0]       off;
   logic [WIDTH-1:0] reg_val;
   logic [31:0]      rd_ext;
   logic             unused_bits;

   assign off   = bAddr[5:0];
   assign we    = bSel & bWrite;
   assign wdata = bWData[WIDTH-1:0];
   assign sync  = sync_ff[SYNC_STAGES-1];
   assign armed = (arm_cnt == ARM_MAX);

   // Edges are suppressed until the synchronizer and prev hold real pad data after reset.
   assign rise     = armed ? (sync & ~prev) : '0;
   assign fall     = armed ? (~sync & prev) : '0;
   assign w1c_mask = (we && off == 6'h18) ? wdata : '0;

   assign unused_bits = ^{bAddr[31:6], bWData};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_ff <= '0;
         prev    <= '0;
         arm_cnt <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], gpioInput};
         prev    <= sync;
         if (!armed) arm_cnt <= arm_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= OUT_RESET;
         dir      <= '0;
         irq_en   <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
      end else if (we) begin
         case (off)
            6'h04:   data_out <= wdata;
            6'h08:   dir      <= wdata;
            6'h0C:   irq_en   <= wdata;
            6'h10:   rise_en  <= wdata;
            6'h14:   fall_en  <= wdata;
            6'h1C:   data_out <= data_out | wdata;
            6'h20:   data_out <= data_out & ~wdata;
            6'h24:   data_out <= data_out ^ wdata;
            default: ;
         endcase
      end
   end

   // A new event in the same cycle as a W1C keeps the bit set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status <= '0;
         irq    <= 1'b0;
      end else begin
         status <= (status & ~w1c_mask) | (rise & rise_en) | (fall & fall_en);
         irq    <= |(status & irq_en);
      end
   end

   always_comb begin
      reg_val = '0;
      case (off)
         6'h00:   reg_val = sync;
         6'h04:   reg_val = data_out;
         6'h08:   reg_val = dir;
         6'h0C:   reg_val = irq_en;
         6'h10:   reg_val = rise_en;
         6'h14:   reg_val = fall_en;
         6'h18:   reg_val = status;
         default: reg_val = '0;
      endcase
      rd_ext = '0;
      rd_ext[WIDTH-1:0] = reg_val;
      case (mem_size)
         2'b00:   bRData = rd_ext;
         2'b01:   bRData = {16'h0000, rd_ext[15:0]};
         2'b10:   bRData = {24'h000000, rd_ext[7:0]};
         default: bRData = 32'h0;
      endcase
   end

   assign gpioOutput = data_out;
   assign gpioOutEn  = dir;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: expected values are queued with the stimulus and popped at each check.
module tb_gpio_irq;

   localparam int          W   = 16;
   localparam int          S   = 2;
   localparam logic [15:0] ORS = 16'h1234;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   bAddr, bWData, bRData;
   logic          bSel, bWrite;
   logic [1:0]    mem_size;
   logic [W-1:0]  gpioInput, gpioOutput, gpioOutEn;
   logic          irq;

   logic [31:0]   exp_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [31:0]   d;

   gpio_irq #(.WIDTH(W), .SYNC_STAGES(S), .OUT_RESET(ORS)) dut (
      .clk(clk), .rst(rst), .bAddr(bAddr), .bWData(bWData), .bSel(bSel),
      .bWrite(bWrite), .mem_size(mem_size), .bRData(bRData),
      .gpioInput(gpioInput), .gpioOutput(gpioOutput), .gpioOutEn(gpioOutEn), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic expect_v(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      bAddr = a; bWData = v; bSel = 1'b1; bWrite = 1'b1; mem_size = 2'b00;
      tick();
      bSel = 1'b0; bWrite = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [1:0] sz, output logic [31:0] v);
      bAddr = a; mem_size = sz;
      #1;
      v = bRData;
   endtask

   initial begin
      rst = 1'b0; bAddr = '0; bWData = '0; bSel = 1'b0; bWrite = 1'b0;
      mem_size = 2'b00; gpioInput = 16'hFFFF;

      // Reset state with all pads high
      ticks(2);
      expect_v({16'h0, ORS}); check("rst_gpioOutput", {16'h0, gpioOutput});
      expect_v(32'h0);        check("rst_gpioOutEn", {16'h0, gpioOutEn});
      expect_v(32'h0);        check("rst_irq", {31'h0, irq});
      rst = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         expect_v(32'h0); rd(32'h18, 2'b00, d); check("no_spurious_status", d);
         if (i == S - 1) begin
            expect_v(32'h0); rd(32'h00, 2'b00, d); check("data_in_early", d);
         end
         if (i == S + 1) begin
            expect_v(32'h0000FFFF); rd(32'h00, 2'b00, d); check("data_in_sync", d);
         end
      end
      expect_v(32'h0); check("no_spurious_irq", {31'h0, irq});

      // Direction and atomic output updates
      wr(32'h08, 32'h00FF);
      wr(32'h04, 32'hA5A5);
      expect_v(32'h00FF); check("dir_oe", {16'h0, gpioOutEn});
      expect_v(32'hA5A5); check("data_out", {16'h0, gpioOutput});
      wr(32'h1C, 32'h000F);
      expect_v(32'hA5AF); check("out_set", {16'h0, gpioOutput});
      wr(32'h20, 32'hA000);
      expect_v(32'h05AF); check("out_clr", {16'h0, gpioOutput});
      wr(32'h24, 32'hFFFF);
      expect_v(32'hFA50); check("out_tgl", {16'h0, gpioOutput});
      expect_v(32'h00000050); rd(32'h04, 2'b10, d); check("rd_byte", d);
      expect_v(32'h0000FA50); rd(32'h04, 2'b01, d); check("rd_half", d);
      expect_v(32'h0);        rd(32'h04, 2'b11, d); check("rd_size11", d);

      // Rising edge on bit 0 with latency check
      gpioInput = 16'h0000;
      ticks(5);
      expect_v(32'h0); rd(32'h18, 2'b00, d); check("falls_not_enabled", d);
      wr(32'h10, 32'h0001);
      wr(32'h0C, 32'h0001);
      gpioInput[0] = 1'b1;
      ticks(S);
      expect_v(32'h0); rd(32'h18, 2'b00, d); check("rise_not_yet", d);
      tick();
      expect_v(32'h1); rd(32'h18, 2'b00, d); check("rise_status", d);
      expect_v(32'h0); check("irq_before", {31'h0, irq});
      tick();
      expect_v(32'h1); check("irq_rise", {31'h0, irq});
      wr(32'h18, 32'h0001);
      expect_v(32'h0); rd(32'h18, 2'b00, d); check("w1c_bit0", d);
      tick();
      expect_v(32'h0); check("irq_drop_bit0", {31'h0, irq});
      gpioInput[0] = 1'b0;
      ticks(5);
      expect_v(32'h0); rd(32'h18, 2'b00, d); check("fall_bit0_ignored", d);

      // W1C colliding with a new falling edge on bit 3
      wr(32'h14, 32'h0008);
      wr(32'h0C, 32'h0008);
      gpioInput[3] = 1'b1; ticks(4);
      gpioInput[3] = 1'b0; ticks(S + 2);
      expect_v(32'h8); rd(32'h18, 2'b00, d); check("fall_bit3", d);
      expect_v(32'h1); check("irq_bit3", {31'h0, irq});
      gpioInput[3] = 1'b1; ticks(4);
      gpioInput[3] = 1'b0; ticks(S);
      wr(32'h18, 32'h0008);
      expect_v(32'h8); rd(32'h18, 2'b00, d); check("event_beats_w1c", d);
      expect_v(32'h1); check("irq_held_collide", {31'h0, irq});
      tick();
      expect_v(32'h1); check("irq_still_high", {31'h0, irq});
      wr(32'h18, 32'h0008);
      expect_v(32'h0); rd(32'h18, 2'b00, d); check("w1c_bit3", d);
      tick();
      expect_v(32'h0); check("irq_drop_bit3", {31'h0, irq});

      // Both edges on bit 4, irq masked until IRQ_EN set
      wr(32'h0C, 32'h0000);
      wr(32'h10, 32'h0010);
      wr(32'h14, 32'h0010);
      for (int k = 0; k < 3; k++) begin
         gpioInput[4] = ~gpioInput[4];
         ticks(S + 1);
         expect_v(32'h10); rd(32'h18, 2'b00, d); check("both_edges_status", d);
         expect_v(32'h0);  check("irq_masked", {31'h0, irq});
         if (k < 2) begin
            wr(32'h18, 32'h0010);
            expect_v(32'h0); rd(32'h18, 2'b00, d); check("w1c_bit4", d);
         end
      end
      wr(32'h0C, 32'h0010);
      expect_v(32'h0); check("irq_en_lag", {31'h0, irq});
      tick();
      expect_v(32'h1); check("irq_en_raise", {31'h0, irq});

      // Asynchronous reset mid-pulse
      gpioInput[4] = ~gpioInput[4];
      tick();
      #2;
      rst = 1'b0;
      #1;
      expect_v(32'h0);        check("async_rst_irq", {31'h0, irq});
      expect_v({16'h0, ORS}); check("async_rst_out", {16'h0, gpioOutput});
      expect_v(32'h0);        check("async_rst_oe", {16'h0, gpioOutEn});
      expect_v(32'h0); rd(32'h18, 2'b00, d); check("async_rst_status", d);
      expect_v(32'h0); rd(32'h0C, 2'b00, d); check("async_rst_irq_en", d);
      tick();
      rst = 1'b1;
      tick();
      expect_v(32'h0); rd(32'h28, 2'b00, d); check("unmapped_rd", d);
      expect_v(32'h0); rd(32'h1C, 2'b00, d); check("write_only_rd", d);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
